fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Instruction-fetch front end that sits directly upstream of the instruction ROM. It owns the program counter and drives the ROM's address and chip-enable. It waits on the ROM's read-finish strobe, captures each fetched word with its PC, and presents them to the IF/ID boundary under a valid/stall handshake. Branch redirects arrive from decode and honour the MIPS delay slot.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TIMEOUT_CYCLES, 64, watchdog limit in REQ cycles. Range 2..65535. Used only with FETCH_TIMEOUT_EN.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold; the held word is not consumed while 1.
- branch_flag  in  1  one-cycle redirect request from decode.
- branch_target  in  32  redirect address; bits [1:0] ignored.
- rom_rfin  in  1  ROM read-finished strobe.
- rom_inst  in  32  ROM read data; valid when rom_rfin=1.
- inst_address  out  32  ROM address; equals pc, word-aligned.
- ce  out  1  ROM enable.
- if_pc  out  32  PC of the held instruction.
- if_inst  out  32  held instruction word.
- if_valid  out  1  if_pc/if_inst hold an unconsumed instruction.
- fetch_err  out  1  one-cycle timeout pulse; constant 0 without FETCH_TIMEOUT_EN.

## Operation
- States: IDLE, REQ, GAP, HOLD.
- IDLE:
  - Entered on reset. ce=0.
  - Next cycle always goes to REQ.
- REQ:
  - ce=1, inst_address=pc.
  - rom_rfin=1: capture if_inst<=rom_inst, if_pc<=pc, set if_valid=1.
  - On capture, pc<=redir_pending ? redir_target : pc+4.
  - After capture: go to HOLD if stall=1, else go to GAP.
- GAP:
  - ce=0 for exactly one cycle, so the ROM read logic rearms.
  - Then go to REQ.
  - if_valid clears here, because a word captured with stall=0 is consumed in the capture cycle.
- HOLD:
  - ce=0; outputs frozen; if_valid=1.
  - On stall=0 the word is consumed: if_valid<=0, go to GAP.
- Consumption rule: a word is consumed on any rising edge with if_valid=1 and stall=0.
- Branch handling:
  - branch_flag=1 in any state latches redir_target<={branch_target[31:2],2'b00} and sets redir_pending.
  - branch_flag is accepted regardless of stall.
  - The in-flight or held word is the delay slot and is never squashed.
  - redir_pending clears when its target is loaded into pc.
  - If branch_flag arrives in the same cycle as a capture, that capture loads the new target directly; redir_pending is not left set.
  - If pc is not updated in that cycle (GAP, HOLD, or REQ without rom_rfin), the target is applied at the next capture.
  - In GAP or HOLD the delay slot is already captured, so the next REQ fetches pc+4 and the capture after it loads the target. The decode stage issues branch_flag in the cycle it sees the branch, while the delay slot is in flight.
  - A second branch_flag while one is pending overwrites redir_target.
- PC arithmetic:
  - 32-bit modulo add; 32'hFFFF_FFFC+4 wraps to 0.
  - pc[1:0] is always 0.
- Reset mid-fetch: all state is cleared immediately, ce drops asynchronously, and any pending redirect is lost.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, ce=0, inst_address=RESET_PC.
  - if_pc=0, if_inst=0, if_valid=0, fetch_err=0.
  - redir_pending=0, redir_target=0, watchdog=0.
- First ce=1 occurs in the second clock after rst deasserts.
- Capture latency: if_valid rises on the edge where rom_rfin=1 is sampled in REQ.
- Minimum fetch period is 3 cycles (REQ, REQ+rfin, GAP) when the ROM finishes one cycle after enable.
- rom_rfin is ignored outside REQ.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A 16-bit watchdog counts consecutive REQ cycles without rom_rfin.
  - When it reaches TIMEOUT_CYCLES, fetch_err pulses for 1 cycle, the state goes to GAP, and the fetch retries the same pc.
  - pc, if_* and redir_* are unchanged by a timeout.
  - The watchdog clears on capture or on leaving REQ.
- FETCH_TIMEOUT_EN undefined: no counter is present; fetch_err is tied to 0; REQ waits indefinitely.

## Test plan
- Reset then free-run, ROM rfin 1 cycle after ce, stall=0 -> inst_address sequence 0,4,8,C. if_valid is high for one cycle every 3 cycles. if_pc matches each address.
- Capture at pc=8 with stall=1 held for 5 cycles -> if_inst and if_pc=8 are frozen, if_valid=1 and ce=0 throughout. Fetch of C starts 2 cycles after stall drops.
- branch_flag with target 32'h0000_0103 during REQ at pc=10 (delay slot) -> word 10 is delivered, then the next fetch address is 32'h0000_0100.
- branch_flag while delay slot at pc=14 is in HOLD, target 32'h0000_0200 -> the next fetch is 18, then 32'h0000_0200. No word is squashed.
- rst pulled low mid-REQ with a redirect pending -> all outputs return to reset values immediately. Fetch restarts at RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, rfin withheld -> fetch_err pulses after 4 REQ cycles, 1 GAP cycle follows, and the same address is re-requested. Without the macro, fetch_err stays 0 and ce stays 1.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch PC controller: drives the ROM, captures words and hands them to IF/ID.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        rom_rfin,
  input  logic [31:0] rom_inst,
  output logic [31:0] inst_address,
  output logic        ce,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_target;
  logic        redir_pending;
  logic [31:0] aligned_target;
  logic [31:0] next_pc;
  logic        capture;
  logic        timeout;
  logic        unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];
  assign aligned_target     = {branch_target[31:2], 2'b00};
  assign capture            = (state == REQ) && rom_rfin;
  assign inst_address       = pc;

  // A redirect arriving with the capture wins over an older pending one.
  assign next_pc = branch_flag   ? aligned_target :
                   redir_pending ? redir_target   :
                   pc + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] watchdog;

  assign timeout = (state == REQ) && !rom_rfin && (watchdog == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      watchdog  <= 16'd0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= timeout;
      if ((state == REQ) && !rom_rfin && !timeout)
        watchdog <= watchdog + 16'd1;
      else
        watchdog <= 16'd0;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      ce            <= 1'b0;
      if_pc         <= 32'd0;
      if_inst       <= 32'd0;
      if_valid      <= 1'b0;
      redir_pending <= 1'b0;
      redir_target  <= 32'd0;
    end else begin
      if (branch_flag) begin
        redir_target  <= aligned_target;
        redir_pending <= !capture;
      end else if (capture) begin
        redir_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          state <= REQ;
          ce    <= 1'b1;
        end
        REQ: begin
          if (rom_rfin) begin
            if_inst  <= rom_inst;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= next_pc;
            ce       <= 1'b0;
            state    <= stall ? HOLD : GAP;
          end else if (timeout) begin
            ce    <= 1'b0;
            state <= GAP;
          end
        end
        // One idle cycle lets the ROM rearm; an unstalled word is gone by now.
        GAP: begin
          if_valid <= 1'b0;
          ce       <= 1'b1;
          state    <= REQ;
        end
        HOLD: begin
          if (!stall) begin
            if_valid <= 1'b0;
            state    <= GAP;
          end
        end
        default: begin
          ce    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Randomised self-checking bench for fetch_pc_ctrl against a behavioural fetch model.
// Define FETCH_TIMEOUT_EN to build with the watchdog (TIMEOUT_CYCLES = 4).
module tb_fetch_pc_ctrl;

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_CYCLES = 4;
`else
  localparam int TO_CYCLES = 64;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst, stall, branch_flag, rom_rfin;
  logic [31:0] branch_target, rom_inst;
  logic [31:0] inst_address, if_pc, if_inst;
  logic        ce, if_valid, fetch_err;

  int assertions = 0;
  int failures   = 0;
  int rom_wait   = 0;
  int lat_min    = 1;
  int lat_max    = 1;

  // Behavioural model of what the fetch unit should be showing.
  logic [31:0] m_pc, m_tgt, m_ipc, m_inst;
  logic        m_ce, m_valid, m_err, m_pend, m_held, m_boot;
  int          m_wd;

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .rom_rfin(rom_rfin), .rom_inst(rom_inst),
    .inst_address(inst_address), .ce(ce), .if_pc(if_pc), .if_inst(if_inst),
    .if_valid(if_valid), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("ce", {31'd0, ce}, {31'd0, m_ce});
    checkOutput("inst_address", inst_address, m_pc);
    checkOutput("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    checkOutput("if_pc", if_pc, m_ipc);
    checkOutput("if_inst", if_inst, m_inst);
    checkOutput("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
  endtask

  task automatic modelReset();
    m_pc = RST_PC; m_tgt = 32'd0; m_ipc = 32'd0; m_inst = 32'd0;
    m_ce = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_pend = 1'b0;
    m_held = 1'b0; m_boot = 1'b1; m_wd = 0;
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic modelStep(input logic s, input logic b, input logic [31:0] t,
                           input logic rfin, input logic [31:0] rinst);
    logic cap, prev_ce;
    cap = m_ce && rfin;
    prev_ce = m_ce;
    m_err = 1'b0;
    if (cap) begin
      m_inst = rinst; m_ipc = m_pc; m_valid = 1'b1;
      m_pc = b ? (t & ~32'd3) : (m_pend ? m_tgt : m_pc + 32'd4);
      m_pend = 1'b0; m_held = s; m_ce = 1'b0; m_wd = 0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_ce = 1'b1;
    end else if (m_ce) begin
`ifdef FETCH_TIMEOUT_EN
      if (m_wd == TO_CYCLES - 1) begin
        m_err = 1'b1; m_ce = 1'b0; m_wd = 0;
      end else m_wd++;
`endif
    end else if (m_held) begin
      if (!s) begin m_held = 1'b0; m_valid = 1'b0; end
    end else begin
      m_valid = 1'b0; m_ce = 1'b1;
    end
    if (b) begin
      m_tgt = t & ~32'd3;
      if (!cap) m_pend = 1'b1;
    end
    if (!prev_ce && m_ce) rom_wait = $urandom_range(lat_max, lat_min);
  endtask

  // Called just after a falling edge: check, drive inputs, predict next edge.
  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t, input logic hold_rom);
    logic        r_fin;
    logic [31:0] r_inst;
    checkAll();
    r_fin  = 1'b0;
    r_inst = $urandom;
    if (m_ce) begin
      if (!hold_rom && rom_wait == 0) r_fin = 1'b1;
      else if (!hold_rom) rom_wait--;
    end else if ($urandom_range(3, 0) == 0) begin
      r_fin = 1'b1;
    end
    stall = s; branch_flag = b; branch_target = t;
    rom_rfin = r_fin; rom_inst = r_inst;
    modelStep(s, b, t, r_fin, r_inst);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    modelReset();
    #1 checkAll();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int   hc;
    logic s, b, done;
    logic [31:0] t;
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'd0;
    rom_rfin = 1'b0; rom_inst = 32'd0;
    @(negedge clk);
    doReset();

    // Free run with stall on the word at 8 and a delay-slot branch at 10.
    hc = 0; done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      s = 1'b0; b = 1'b0; t = 32'd0;
      if (hc > 0) begin s = 1'b1; hc--; end
      else if (!done && m_ce && m_pc == 32'h8 && rom_wait == 0) begin s = 1'b1; hc = 5; done = 1'b1; end
      if (m_ce && m_pc == 32'h10) begin b = 1'b1; t = 32'h0000_0103; end
      applyStimulus(s, b, t, 1'b0);
    end

    // Branch issued while the delay slot at 14 is held.
    doReset();
    hc = 0; done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      s = 1'b0; b = 1'b0; t = 32'd0;
      if (hc > 0) begin
        s = 1'b1;
        if (hc == 2) begin b = 1'b1; t = 32'h0000_0200; end
        hc--;
      end else if (!done && m_ce && m_pc == 32'h14 && rom_wait == 0) begin
        s = 1'b1; hc = 3; done = 1'b1;
      end
      applyStimulus(s, b, t, 1'b0);
    end

    // Reset in the middle of a REQ with a redirect pending.
    for (int i = 0; i < 6 && !m_ce; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    #2 doReset();
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    // ROM never answers: watchdog pulse or indefinite wait.
    doReset();
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    // Address wrap at the top of memory.
    doReset();
    done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = !done && m_ce && m_pc == RST_PC && rom_wait == 0;
      if (b) done = 1'b1;
      applyStimulus(1'b0, b, 32'hFFFF_FFFE, 1'b0);
    end

    // Random traffic: stalls, branches, variable ROM latency.
    lat_min = 0; lat_max = 5;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(99, 0) < 30);
      b = ($urandom_range(99, 0) < 10);
      t = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : ($urandom & 32'h0000_0FFF);
      applyStimulus(s, b, t, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
